// File: rtl/jt12_eg_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : jt12_eg_seq_if
// Description : Bundle between the envelope sequencer and its surroundings
//               (register file plus combinational envelope datapath).
//               master : drives slot parameters and datapath results
//               slave  : the sequencer, presents the per-slot context
// Ports       : clk_en, kon, ar, d1r, d2r, rr, sl, eg_next, sum_up (to seq)
//               slot, state, base_rate, eg_cnt, cnt_in, eg_in   (from seq)
// Revision    : 1.0 - initial release
// ============================================================================
interface jt12_eg_seq_if;
  logic        clk_en;
  logic        kon;
  logic [4:0]  ar;
  logic [4:0]  d1r;
  logic [4:0]  d2r;
  logic [3:0]  rr;
  logic [3:0]  sl;
  logic [9:0]  eg_next;
  logic        sum_up;
  logic [4:0]  slot;
  logic [2:0]  state;
  logic [4:0]  base_rate;
  logic [14:0] eg_cnt;
  logic        cnt_in;
  logic [9:0]  eg_in;

  modport master (
    output clk_en, kon, ar, d1r, d2r, rr, sl, eg_next, sum_up,
    input  slot, state, base_rate, eg_cnt, cnt_in, eg_in
  );

  modport slave (
    input  clk_en, kon, ar, d1r, d2r, rr, sl, eg_next, sum_up,
    output slot, state, base_rate, eg_cnt, cnt_in, eg_in
  );
endinterface
`default_nettype wire

// File: rtl/jt12_eg_seq.sv
`default_nettype none
// ============================================================================
// Module      : jt12_eg_seq
// Description : Per-slot sequencer for the time-multiplexed envelope
//               generator. Holds {state, level, cnt_bit, kon_prev} for every
//               operator slot, steps the slot counter and the global 15-bit
//               envelope counter, presents the addressed slot's context to
//               the combinational datapath and writes its result back while
//               applying the ADSR state transitions.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               bus    - jt12_eg_seq_if.slave (slot params in, context out)
// Revision    : 1.0 - initial release
// ============================================================================
module jt12_eg_seq #(
  parameter int SLOTS = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  jt12_eg_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_ATTACK  = 3'd0,
    ST_DECAY1  = 3'd1,
    ST_DECAY2  = 3'd2,
    ST_RELEASE = 3'd7
  } eg_state_e;

  localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);
  localparam logic [9:0] LEVEL_MAX = 10'h3FF;

  // Counters
  logic [4:0]  slot_q, slot_d;
  logic [1:0]  div_q, div_d;
  logic [14:0] eg_cnt_q, eg_cnt_d;

  // Per-slot storage
  eg_state_e   st_q   [SLOTS];
  logic [9:0]  lvl_q  [SLOTS];
  logic        cnt_q  [SLOTS];
  logic        konp_q [SLOTS];

  // Context of the slot currently addressed
  eg_state_e   cur_st;
  logic [9:0]  cur_lvl;
  logic        cur_cnt;
  logic        cur_konp;

  eg_state_e   st_d;
  logic [9:0]  sl_lvl;
  logic        wrap;

  assign cur_st   = st_q[slot_q];
  assign cur_lvl  = lvl_q[slot_q];
  assign cur_cnt  = cnt_q[slot_q];
  assign cur_konp = konp_q[slot_q];

  assign wrap = (slot_q == LAST_SLOT);

  // Counter next-state: the divider only moves on a slot wrap, and the
  // envelope counter only on the wrap that takes the divider 2 -> 0.
  always_comb begin
    slot_d   = slot_q + 5'd1;
    div_d    = div_q;
    eg_cnt_d = eg_cnt_q;
    if (wrap) begin
      slot_d = 5'd0;
      if (div_q == 2'd2) begin
        div_d    = 2'd0;
        eg_cnt_d = eg_cnt_q + 15'd1;
      end else begin
        div_d = div_q + 2'd1;
      end
    end
  end

  // Sustain level: sl scaled by 32, with the top code pushed to 0x3E0 so the
  // maximum sustain sits near full attenuation.
  always_comb begin
    sl_lvl = {1'b0, bus.sl, 5'd0};
    if (bus.sl == 4'hF) begin
      sl_lvl = 10'h3E0;
    end
  end

  // ADSR transition for the addressed slot. Key edges dominate the
  // level-driven transitions.
  always_comb begin
    st_d = cur_st;
    if (bus.kon && !cur_konp) begin
      st_d = ST_ATTACK;
    end else if (!bus.kon && cur_konp) begin
      st_d = ST_RELEASE;
    end else if (cur_st == ST_ATTACK && bus.eg_next == 10'd0) begin
      st_d = ST_DECAY1;
    end else if (cur_st == ST_DECAY1 && bus.eg_next >= sl_lvl) begin
      st_d = ST_DECAY2;
    end
  end

  always_comb begin
    bus.base_rate = 5'd0;
    case (cur_st)
      ST_ATTACK:  bus.base_rate = bus.ar;
      ST_DECAY1:  bus.base_rate = bus.d1r;
      ST_DECAY2:  bus.base_rate = bus.d2r;
      ST_RELEASE: bus.base_rate = {bus.rr, 1'b1};
      default:    bus.base_rate = 5'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= 5'd0;
      div_q    <= 2'd0;
      eg_cnt_q <= 15'd0;
    end else if (bus.clk_en) begin
      slot_q   <= slot_d;
      div_q    <= div_d;
      eg_cnt_q <= eg_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        st_q[i]   <= ST_RELEASE;
        lvl_q[i]  <= LEVEL_MAX;
        cnt_q[i]  <= 1'b0;
        konp_q[i] <= 1'b0;
      end
    end else if (bus.clk_en) begin
      st_q[slot_q]   <= st_d;
      lvl_q[slot_q]  <= bus.eg_next;
      cnt_q[slot_q]  <= cur_cnt ^ bus.sum_up;
      konp_q[slot_q] <= bus.kon;
    end
  end

  assign bus.slot   = slot_q;
  assign bus.state  = cur_st;
  assign bus.eg_cnt = eg_cnt_q;
  assign bus.cnt_in = cur_cnt;
  assign bus.eg_in  = cur_lvl;

endmodule
`default_nettype wire

// File: doc/jt12_eg_seq.md
# jt12_eg_seq

Per-slot sequencer for the time-multiplexed envelope generator datapath. It stores the envelope state, attenuation level, count-phase bit and key-on history for 24 operator slots. It steps a slot counter and the global 15-bit envelope counter, and presents each slot's context to the combinational envelope datapath. It writes the datapath's result back and applies the ADSR state transitions.

## Interface
Parameters:
- SLOTS, 24: number of time-multiplexed operator slots.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  slot advance enable; all state changes only on clk rising edge with clk_en=1.
- kon  in  1  key-on for the current slot (register file output aligned to `slot`).
- ar  in  5  attack rate for the current slot.
- d1r  in  5  first decay rate for the current slot.
- d2r  in  5  second decay rate for the current slot.
- rr  in  4  release rate for the current slot.
- sl  in  4  sustain level for the current slot.
- eg_next  in  10  next attenuation computed by the datapath for the current slot.
- sum_up  in  1  datapath flag: the counter phase changed for this slot.
- slot  out  5  current slot index, 0..SLOTS-1.
- state  out  3  current slot state: ATTACK=0, DECAY1=1, DECAY2=2, RELEASE=7.
- base_rate  out  5  rate selected for the current state.
- eg_cnt  out  15  global envelope counter.
- cnt_in  out  1  stored counter-phase bit of the current slot.
- eg_in  out  10  stored attenuation of the current slot.

## Operation
- Per-slot storage holds SLOTS entries of {state 3b, level 10b, cnt_bit 1b, kon_prev 1b}. Storage may be a RAM indexed by `slot` or a circular shift register.
- `state`, `eg_in` and `cnt_in` show the entry addressed by `slot`.
- `base_rate` is combinational:
  - ATTACK: ar.
  - DECAY1: d1r.
  - DECAY2: d2r.
  - RELEASE: {rr,1'b1}.
  - Any other code: 0.
- Write-back on each enabled edge to entry[slot]:
  - level: eg_next.
  - cnt_bit: cnt_bit ^ sum_up.
  - kon_prev: kon.
  - state: state_next.
- state_next priority, first match wins:
  1. kon=1 and kon_prev=0: ATTACK. The level still takes eg_next; the attack starts from the current level.
  2. kon=0 and kon_prev=1: RELEASE.
  3. ATTACK and eg_next==0: DECAY1.
  4. DECAY1 and eg_next >= sl_lvl: DECAY2. sl_lvl = {1'b0,sl,5'd0}, except sl=15 gives 10'h3E0.
  5. Otherwise: state unchanged.
- DECAY2 and RELEASE never leave by themselves; they saturate at 0x3FF through the datapath.
- Slot counter: increments on each enabled edge and wraps SLOTS-1 -> 0.
- Divider: a 2-bit divider (0..2) increments on each slot wrap.
- eg_cnt: increments when a slot wrap occurs with divider==2. It wraps 0x7FFF -> 0.

## Timing
- Reset values: slot=0, eg_cnt=0, divider=0.
- Reset values of every entry: state=RELEASE, level=0x3FF, cnt_bit=0, kon_prev=0.
- Outputs right after reset: state=7, eg_in=0x3FF, cnt_in=0, slot=0, eg_cnt=0.
- Reset asserted mid-operation returns all storage and counters to the reset values immediately, without waiting for a clock edge.
- Latency: the datapath is combinational. A slot's context is presented and its result captured within one enabled cycle.
- A slot is revisited every SLOTS enabled cycles.
- clk_en=0 freezes all registers, so outputs are held.
- eg_cnt changes on the same edge on which slot goes SLOTS-1 -> 0. The new value is first seen by slot 0. One eg_cnt period is 3*SLOTS enabled cycles.
- Simultaneous key-on edge and eg_next==0: state goes to ATTACK, since the key-on edge has priority.
- Simultaneous key-off edge and DECAY1 reaching sl_lvl: state goes to RELEASE.
- The register file must present slot-aligned parameters combinationally, in the same cycle as `slot`.

## Test plan
- Reset release with clk_en=1: slot steps 0,1,..,23,0; eg_cnt=1 exactly after 72 enabled cycles; all slots read state=7 and eg_in=0x3FF on their first visit.
- Slot 5 key-on: kon=1 on slot 5, with the datapath model returning eg_next=0x3FF-0x100.
  - Next visit of slot 5 shows state=0 and eg_in=0x2FF.
  - Other slots are unchanged.
- Attack end: slot 5 in ATTACK, eg_next=0 -> next visit state=1. Then with sl=4 and eg_next=0x080 -> state=2. With eg_next=0x07F, state stays 1.
- sl=15 boundary: eg_next=0x3DF keeps DECAY1; eg_next=0x3E0 -> DECAY2.
- Key-off: kon=0 on slot 5 in DECAY2 -> state=7 and base_rate={rr,1}; with rr=0xA, base_rate=0x15.
  - Re-asserting kon -> state=0.
  - Simultaneous key-on edge with eg_next=0 -> state=0.
- cnt_in and clk_en:
  - sum_up=1 on slot 3 toggles cnt_in at its next visit; sum_up=0 keeps it.
  - clk_en=0 for 10 cycles holds slot, eg_cnt and all outputs.
  - rst_n low mid-frame restores all reset values asynchronously.
